l5_apical_coupling: RTL
=======================

Name: l5_apical_coupling

Overview:
- Downstream consumer of the L1 apical gain.
- Models the L5 pyramidal soma/apical interaction:
  - Scales basal (feedforward) drive by apical_gain in Q14 fixed point.
  - Detects basal/apical coincidence and generates BAC-style bursts.
  - Enforces a refractory period after each burst.
- All state advances only on clk_en ticks, which occur at the 4 kHz model rate.

Parameters:
- WIDTH, 18, signed data width.
- FRAC, 14, fractional bits (Q14, 1.0 = 16384).
- GAIN_THRESH, 20480, apical_gain level (1.25) that primes a burst.
- BASAL_THRESH, 4096, basal_input level (0.25) that counts as coincidence.
- COINC_WIN, 20, ticks the PRIMED state waits for basal coincidence.
- BURST_LEN, 8, ticks spent in BURST.
- REFRAC, 40, ticks spent in REFRACTORY.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- clk_en, input, 1, single-cycle model-rate strobe.
- basal_input, input, WIDTH signed, basal drive in Q14.
- apical_gain, input, WIDTH signed, gain from L1 in Q14, nominally in [4096, 32768].
- modulated_output, output, WIDTH signed, gain-scaled drive in Q14.
- burst_active, output, 1, high while the FSM is in BURST.
- burst_count, output, 8, saturating count of burst entries.
- state_out, output, 2, FSM state: 0 IDLE, 1 PRIMED, 2 BURST, 3 REFRACTORY.

Behaviour:
- Reset:
  - The single clock is clk; rst_n is asynchronous and active-low.
  - While rst_n = 0: modulated_output = 0, burst_active = 0, burst_count = 0, state = IDLE, all counters = 0.
  - Reset asserted mid-burst aborts immediately. No residual state survives.
- clk_en = 0: every register holds its value.
- Arithmetic:
  - prod = basal_input * apical_gain, computed at full 2*WIDTH precision.
  - scaled = prod >>> FRAC, an arithmetic shift that truncates toward negative infinity.
  - In BURST, scaled is doubled (<<<1) before saturation.
  - The result saturates to [-131072, 131071].
  - modulated_output registers on the clk edge where clk_en = 1, using the inputs present at that edge. Latency is one tick.
  - The doubling decision uses the state value before that edge's update.
- Comparisons are signed `>=` against the thresholds.
- FSM, evaluated on clk_en ticks only:
  - IDLE:
    - If gain >= GAIN_THRESH and basal >= BASAL_THRESH: go to BURST and load burst_cnt = BURST_LEN.
    - Else if gain >= GAIN_THRESH: go to PRIMED and load win_cnt = COINC_WIN.
    - Else: stay in IDLE.
  - PRIMED, checked in this priority order:
    - basal >= BASAL_THRESH: go to BURST. Coincidence wins over a same-tick gain drop.
    - gain < GAIN_THRESH: go to IDLE.
    - win_cnt == 1: go to IDLE (window expired).
    - Otherwise: decrement win_cnt.
    - With gain held high and no basal input, PRIMED lasts exactly COINC_WIN ticks. The next tick then re-primes from IDLE.
  - BURST:
    - burst_active = 1.
    - Decrement burst_cnt.
    - On the tick where burst_cnt == 1, go to REFRACTORY and load ref_cnt = REFRAC.
    - Inputs are ignored for state decisions.
  - REFRACTORY:
    - Inputs are ignored for state decisions.
    - On the tick where ref_cnt == 1, go to IDLE.
- BURST and REFRACTORY therefore last exactly BURST_LEN and REFRAC ticks respectively.
- burst_count:
  - Increments on each entry into BURST.
  - Saturates at 255 and never wraps.
- burst_active and state_out are registered and change on the same edge as the state.

Decomposition:
- Shared package/include holds:
  - Q14 constants: ONE = 16384, GAIN_MAX = 32768, GAIN_MIN = 4096.
  - Default thresholds.
  - The 2-bit FSM state encoding (IDLE/PRIMED/BURST/REFRACTORY) as localparams, so L1/L5 benches can reuse them.
- One sub-module, q14_mul_sat: a combinational signed multiply with shift, optional x2, and saturation, reused by later layer stages.
- The FSM and counters stay in the top level.

Test Plan:
- Reset and hold:
  - Stimulus: assert rst_n = 0 mid-BURST.
  - Required: all outputs read 0 and state_out = 0 immediately, without waiting for a clock edge.
  - Then release reset with clk_en held low for 50 clocks; outputs must stay 0.
- Scaling:
  - Stimulus: basal = 8192 (0.5), gain = 16384.
  - Required: modulated_output = 8192 after one tick.
  - Then set gain = 32768; output = 16384.
  - Then set basal = 65536, gain = 32768; output saturates to 131071.
  - Then set basal = -65536; output saturates to -131072.
- Window expiry:
  - Stimulus: gain = 24576, basal = 0.
  - Required: PRIMED for exactly 20 ticks, then IDLE for one tick, then PRIMED again.
  - burst_count stays 0.
- Coincidence burst:
  - Stimulus: gain = 24576; on the 5th PRIMED tick set basal = 8192.
  - Required: BURST for 8 ticks with burst_active = 1, output = 2 * (8192 * 24576 >> 14) = 24576.
  - Then REFRACTORY for 40 ticks, ignoring held inputs, then back to IDLE.
  - burst_count = 1.
- Priority:
  - Stimulus: in PRIMED, on the same tick drop gain to 16384 and raise basal to 4096.
  - Required: the next state is BURST.
  - Also from IDLE, raising gain and basal together must go directly to BURST.
- Saturation of count:
  - Stimulus: 300 back-to-back coincidence cycles with BURST_LEN = 1 and REFRAC = 1.
  - Required: burst_count = 255.

Source files
------------

// File: rtl/l5_apical_coupling_pkg.sv
// Shared Q14 constants, default thresholds and L5 FSM state encoding.
package l5_apical_coupling_pkg;

    // Q14 reference points
    localparam int ONE      = 16384;
    localparam int GAIN_MAX = 32768;
    localparam int GAIN_MIN = 4096;

    // Default layer-5 thresholds and timing (in model-rate ticks)
    localparam int DEF_GAIN_THRESH  = 20480;
    localparam int DEF_BASAL_THRESH = 4096;
    localparam int DEF_COINC_WIN    = 20;
    localparam int DEF_BURST_LEN    = 8;
    localparam int DEF_REFRAC       = 40;

    // Width of the window/burst/refractory down-counters
    localparam int CNT_W = 16;

    // 2-bit state encoding, exported as plain constants so benches can reuse them
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRIMED     = 2'd1;
    localparam logic [1:0] ST_BURST      = 2'd2;
    localparam logic [1:0] ST_REFRACTORY = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        PRIMED     = ST_PRIMED,
        BURST      = ST_BURST,
        REFRACTORY = ST_REFRACTORY
    } l5_state_e;

endpackage

// File: rtl/l5_apical_coupling_q14_mul_sat.sv
// Combinational signed Q-format multiply: full-precision product, arithmetic
// shift (floor), optional x2, then saturation back to WIDTH bits.
module q14_mul_sat #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    dbl,
    output logic signed [WIDTH-1:0] y
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [PW-1:0] dbl_v;

    // Product never overflows PW bits, and x2 of the shifted value still fits
    always_comb begin
        prod   = PW'(a) * PW'(b);
        scaled = prod >>> FRAC;
        dbl_v  = dbl ? (scaled <<< 1) : scaled;
        if (dbl_v > MAXV)      y = MAXV[WIDTH-1:0];
        else if (dbl_v < MINV) y = MINV[WIDTH-1:0];
        else                   y = dbl_v[WIDTH-1:0];
    end

endmodule

// File: rtl/l5_apical_coupling.sv
// L5 pyramidal soma/apical coupling: gain-scaled basal drive plus a
// PRIMED -> BURST -> REFRACTORY coincidence FSM, advanced on clk_en ticks.
module l5_apical_coupling
    import l5_apical_coupling_pkg::*;
#(
    parameter int WIDTH        = 18,
    parameter int FRAC         = 14,
    parameter int GAIN_THRESH  = DEF_GAIN_THRESH,
    parameter int BASAL_THRESH = DEF_BASAL_THRESH,
    parameter int COINC_WIN    = DEF_COINC_WIN,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int REFRAC       = DEF_REFRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] basal_input,
    input  logic signed [WIDTH-1:0] apical_gain,
    output logic signed [WIDTH-1:0] modulated_output,
    output logic                    burst_active,
    output logic [7:0]              burst_count,
    output logic [1:0]              state_out
);
    localparam logic signed [WIDTH-1:0] GAIN_TH  = WIDTH'(GAIN_THRESH);
    localparam logic signed [WIDTH-1:0] BASAL_TH = WIDTH'(BASAL_THRESH);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);

    l5_state_e               state_q, state_d;
    logic [CNT_W-1:0]        win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]        ref_cnt_q, ref_cnt_d;
    logic [7:0]              burst_count_q, burst_count_d;
    logic                    burst_active_q, burst_active_d;
    logic signed [WIDTH-1:0] mod_q, mod_d;
    logic signed [WIDTH-1:0] scaled;
    logic                    gain_hi, basal_hi;

    assign gain_hi  = apical_gain >= GAIN_TH;
    assign basal_hi = basal_input >= BASAL_TH;

    // Doubling keys off the pre-edge state, so the entry tick is not doubled
    q14_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .a   (basal_input),
        .b   (apical_gain),
        .dbl (state_q == BURST),
        .y   (scaled)
    );

    // Next-state, counters and registered outputs; everything holds without clk_en
    always_comb begin
        state_d        = state_q;
        win_cnt_d      = win_cnt_q;
        burst_cnt_d    = burst_cnt_q;
        ref_cnt_d      = ref_cnt_q;
        burst_count_d  = burst_count_q;
        burst_active_d = burst_active_q;
        mod_d          = mod_q;
        if (clk_en) begin
            mod_d = scaled;
            case (state_q)
                IDLE: begin
                    if (gain_hi && basal_hi) begin
                        state_d     = BURST;
                        burst_cnt_d = CNT_W'(BURST_LEN);
                    end else if (gain_hi) begin
                        state_d   = PRIMED;
                        win_cnt_d = CNT_W'(COINC_WIN);
                    end
                end
                PRIMED: begin
                    // Coincidence beats a same-tick gain drop
                    if (basal_hi) begin
                        state_d     = BURST;
                        burst_cnt_d = CNT_W'(BURST_LEN);
                    end else if (!gain_hi || win_cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q - CNT_ONE;
                    end
                end
                BURST: begin
                    burst_cnt_d = burst_cnt_q - CNT_ONE;
                    if (burst_cnt_q == CNT_ONE) begin
                        state_d   = REFRACTORY;
                        ref_cnt_d = CNT_W'(REFRAC);
                    end
                end
                REFRACTORY: begin
                    ref_cnt_d = ref_cnt_q - CNT_ONE;
                    if (ref_cnt_q == CNT_ONE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (state_d == BURST && state_q != BURST && burst_count_q != 8'hFF)
                burst_count_d = burst_count_q + 8'd1;
            burst_active_d = (state_d == BURST);
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            win_cnt_q      <= '0;
            burst_cnt_q    <= '0;
            ref_cnt_q      <= '0;
            burst_count_q  <= '0;
            burst_active_q <= 1'b0;
            mod_q          <= '0;
        end else begin
            state_q        <= state_d;
            win_cnt_q      <= win_cnt_d;
            burst_cnt_q    <= burst_cnt_d;
            ref_cnt_q      <= ref_cnt_d;
            burst_count_q  <= burst_count_d;
            burst_active_q <= burst_active_d;
            mod_q          <= mod_d;
        end
    end

    assign modulated_output = mod_q;
    assign burst_active     = burst_active_q;
    assign burst_count      = burst_count_q;
    assign state_out        = state_q;

endmodule
